// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises instruction-fetch and load/store requests onto a
// single RAM request/acknowledge port. Round-robin on conflicts, one-cycle
// ihit/dhit pulses, all outputs registered.
module mem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned LDST_WIDTH_W = 3,
  // Size code used for instruction reads (word access).
  parameter logic [LDST_WIDTH_W-1:0] LDST_WORD = LDST_WIDTH_W'(2)
) (
  input  logic                    clk,
  input  logic                    nrst,
  // Instruction fetch port
  input  logic                    iren,
  input  logic [ADDR_W-1:0]       iaddr,
  output logic                    ihit,
  output logic [DATA_W-1:0]       idata,
  // Load/store port
  input  logic                    dren,
  input  logic                    dwen,
  input  logic [ADDR_W-1:0]       daddr,
  input  logic [DATA_W-1:0]       dstore,
  input  logic [LDST_WIDTH_W-1:0] dwidth,
  output logic                    dhit,
  output logic [DATA_W-1:0]       dload,
  // RAM port
  output logic                    ram_req,
  output logic                    ram_wen,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [DATA_W-1:0]       ram_wdata,
  output logic [LDST_WIDTH_W-1:0] ram_width,
  input  logic                    ram_ack,
  input  logic [DATA_W-1:0]       ram_rdata
);

  typedef enum logic [2:0] {
    StIdle,
    StIreq,
    StDreq,
    StIresp,
    StDresp
  } state_e;

  state_e                  state_q;
  logic                    last_grant_q;  // 0: instruction side, 1: data side
  logic                    ram_req_q;
  logic                    ram_wen_q;
  logic [ADDR_W-1:0]       ram_addr_q;
  logic [DATA_W-1:0]       ram_wdata_q;
  logic [LDST_WIDTH_W-1:0] ram_width_q;
  logic                    ihit_q;
  logic                    dhit_q;
  logic [DATA_W-1:0]       idata_q;
  logic [DATA_W-1:0]       dload_q;

  logic i_pend;
  logic d_pend;
  logic grant_data;

  // Grant decision in IDLE: data wins when alone, or on a conflict after an I grant.
  always_comb begin
    i_pend     = iren;
    d_pend     = dren | dwen;
    grant_data = d_pend & (~i_pend | ~last_grant_q);
  end

  // Arbiter FSM with registered RAM fields, hit pulses and read data.
  always_ff @(posedge clk) begin
    if (nrst) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b0;
      ram_req_q    <= 1'b0;
      ram_wen_q    <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      ram_width_q  <= '0;
      ihit_q       <= 1'b0;
      dhit_q       <= 1'b0;
      idata_q      <= '0;
      dload_q      <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (grant_data) begin
            state_q      <= StDreq;
            last_grant_q <= 1'b1;
            ram_req_q    <= 1'b1;
            ram_wen_q    <= dwen;  // dren & dwen together is a store
            ram_addr_q   <= daddr;
            ram_wdata_q  <= dstore;
            ram_width_q  <= dwidth;
          end else if (i_pend) begin
            state_q      <= StIreq;
            last_grant_q <= 1'b0;
            ram_req_q    <= 1'b1;
            ram_wen_q    <= 1'b0;
            ram_addr_q   <= iaddr;
            ram_wdata_q  <= '0;    // fetches never write
            ram_width_q  <= LDST_WORD;
          end
        end
        StIreq: begin
          if (ram_ack) begin
            idata_q   <= ram_rdata;
            ram_req_q <= 1'b0;
            ihit_q    <= 1'b1;
            state_q   <= StIresp;
          end
        end
        StDreq: begin
          if (ram_ack) begin
            if (!ram_wen_q) begin
              dload_q <= ram_rdata;
            end
            ram_req_q <= 1'b0;
            dhit_q    <= 1'b1;
            state_q   <= StDresp;
          end
        end
        StIresp: begin
          // No arbitration here, so a still-held request is not re-granted.
          ihit_q  <= 1'b0;
          state_q <= StIdle;
        end
        StDresp: begin
          dhit_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign ram_req   = ram_req_q;
  assign ram_wen   = ram_wen_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_width = ram_width_q;
  assign ihit      = ihit_q;
  assign dhit      = dhit_q;
  assign idata     = idata_q;
  assign dload     = dload_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: cycle-by-cycle vector table followed by
// a hand-written round-robin sequence with a variable-latency RAM responder.
module tb_mem_arbiter;

  localparam logic [2:0] WB = 3'd0;  // byte
  localparam logic [2:0] WH = 3'd1;  // half
  localparam logic [2:0] WW = 3'd2;  // word

  typedef struct packed {
    logic        rst;
    logic        iren;
    logic [31:0] iaddr;
    logic        dren;
    logic        dwen;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [2:0]  dwidth;
    logic        ack;
    logic [31:0] rdata;
  } in_t;

  // Field order: req, wen, addr, wdata, width, ihit, dhit, idata, dload
  typedef struct packed {
    logic        req;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  width;
    logic        ihit;
    logic        dhit;
    logic [31:0] idata;
    logic [31:0] dload;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  logic        clk;
  logic        nrst;
  logic        iren;
  logic [31:0] iaddr;
  logic        ihit;
  logic [31:0] idata;
  logic        dren;
  logic        dwen;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [2:0]  dwidth;
  logic        dhit;
  logic [31:0] dload;
  logic        ram_req;
  logic        ram_wen;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [2:0]  ram_width;
  logic        ram_ack;
  logic [31:0] ram_rdata;

  int checks;
  int errors;
  vec_t vecs[$];

  mem_arbiter dut (
    .clk       (clk),
    .nrst      (nrst),
    .iren      (iren),
    .iaddr     (iaddr),
    .ihit      (ihit),
    .idata     (idata),
    .dren      (dren),
    .dwen      (dwen),
    .daddr     (daddr),
    .dstore    (dstore),
    .dwidth    (dwidth),
    .dhit      (dhit),
    .dload     (dload),
    .ram_req   (ram_req),
    .ram_wen   (ram_wen),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_width (ram_width),
    .ram_ack   (ram_ack),
    .ram_rdata (ram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic in_t iv(logic r, logic ie, logic [31:0] ia, logic dr, logic dw,
                             logic [31:0] da, logic [31:0] ds, logic [2:0] dwd,
                             logic ak, logic [31:0] rd);
    iv = '{rst: r, iren: ie, iaddr: ia, dren: dr, dwen: dw, daddr: da, dstore: ds,
           dwidth: dwd, ack: ak, rdata: rd};
  endfunction

  function automatic out_t ov(logic rq, logic we, logic [31:0] ad, logic [31:0] wd,
                              logic [2:0] wt, logic ih, logic dh, logic [31:0] id,
                              logic [31:0] dl);
    ov = '{req: rq, wen: we, addr: ad, wdata: wd, width: wt, ihit: ih, dhit: dh,
           idata: id, dload: dl};
  endfunction

  task automatic add(input in_t a, input out_t b);
    vec_t v;
    v.i = a;
    v.o = b;
    vecs.push_back(v);
  endtask

  function automatic out_t sample();
    sample = '{req: ram_req, wen: ram_wen, addr: ram_addr, wdata: ram_wdata,
               width: ram_width, ihit: ihit, dhit: dhit, idata: idata, dload: dload};
  endfunction

  task automatic check(input string name, input logic ok, input string got,
                       input string want);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %s required %s", name, got, want);
    end
  endtask

  initial begin
    out_t act;
    logic [31:0] i1, l1;
    checks = 0;
    errors = 0;
    nrst = 1'b1; iren = 1'b0; iaddr = '0; dren = 1'b0; dwen = 1'b0;
    daddr = '0; dstore = '0; dwidth = '0; ram_ack = 1'b0; ram_rdata = '0;

    i1 = 32'h0050_0093;
    l1 = 32'h1234_5678;
    // Each row: inputs held for one cycle, expected outputs after that rising edge.
    // Reset and idle
    add(iv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), ov(0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(iv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ov(0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Lone fetch, ack in first request cycle
    add(iv(0, 1, 'h100, 0, 0, 0, 0, 0, 0, 0), ov(1, 0, 'h100, 0, WW, 0, 0, 0, 0));
    add(iv(0, 1, 'h100, 0, 0, 0, 0, 0, 1, i1), ov(0, 0, 'h100, 0, WW, 1, 0, i1, 0));
    add(iv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ov(0, 0, 'h100, 0, WW, 0, 0, i1, 0));
    // Byte store, slow RAM, requester inputs wander while waiting
    add(iv(0, 0, 0, 0, 1, 'h2004, 'hDEADBEEF, WB, 0, 0),
        ov(1, 1, 'h2004, 'hDEADBEEF, WB, 0, 0, i1, 0));
    add(iv(0, 0, 0, 0, 1, 'hFFFC, 'h0BADF00D, WW, 0, 0),
        ov(1, 1, 'h2004, 'hDEADBEEF, WB, 0, 0, i1, 0));
    add(iv(0, 0, 0, 0, 1, 'hFFFC, 'h0BADF00D, WW, 0, 'h77),
        ov(1, 1, 'h2004, 'hDEADBEEF, WB, 0, 0, i1, 0));
    add(iv(0, 0, 0, 0, 1, 'hFFFC, 'h0BADF00D, WW, 0, 0),
        ov(1, 1, 'h2004, 'hDEADBEEF, WB, 0, 0, i1, 0));
    add(iv(0, 0, 0, 0, 1, 'hFFFC, 'h0BADF00D, WW, 1, 'hAAAAAAAA),
        ov(0, 1, 'h2004, 'hDEADBEEF, WB, 0, 1, i1, 0));
    add(iv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ov(0, 1, 'h2004, 'hDEADBEEF, WB, 0, 0, i1, 0));
    // Load data capture
    add(iv(0, 0, 0, 1, 0, 'h3000, 0, WW, 0, 0), ov(1, 0, 'h3000, 0, WW, 0, 0, i1, 0));
    add(iv(0, 0, 0, 1, 0, 'h3000, 0, WW, 1, l1), ov(0, 0, 'h3000, 0, WW, 0, 1, i1, l1));
    add(iv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ov(0, 0, 'h3000, 0, WW, 0, 0, i1, l1));
    add(iv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ov(0, 0, 'h3000, 0, WW, 0, 0, i1, l1));
    // Fetch held through ihit: no grant in hit cycle, re-grant one cycle later
    add(iv(0, 1, 'h200, 0, 0, 0, 0, 0, 0, 0), ov(1, 0, 'h200, 0, WW, 0, 0, i1, l1));
    add(iv(0, 1, 'h200, 0, 0, 0, 0, 0, 1, 'h11111111),
        ov(0, 0, 'h200, 0, WW, 1, 0, 'h11111111, l1));
    add(iv(0, 1, 'h200, 0, 0, 0, 0, 0, 0, 0), ov(0, 0, 'h200, 0, WW, 0, 0, 'h11111111, l1));
    add(iv(0, 1, 'h200, 0, 0, 0, 0, 0, 0, 0), ov(1, 0, 'h200, 0, WW, 0, 0, 'h11111111, l1));
    add(iv(0, 0, 0, 0, 0, 0, 0, 0, 1, 'h22222222),
        ov(0, 0, 'h200, 0, WW, 1, 0, 'h22222222, l1));
    add(iv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ov(0, 0, 'h200, 0, WW, 0, 0, 'h22222222, l1));
    // Reset in DREQ, late ack ignored
    add(iv(0, 0, 0, 1, 0, 'h4000, 0, WH, 0, 0),
        ov(1, 0, 'h4000, 0, WH, 0, 0, 'h22222222, l1));
    add(iv(1, 0, 0, 1, 0, 'h4000, 0, WH, 0, 0), ov(0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(iv(0, 0, 0, 0, 0, 0, 0, 0, 1, 'h99999999), ov(0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(iv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ov(0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Conflicts after reset: D, I, D
    add(iv(0, 1, 'h500, 1, 0, 'h600, 0, WW, 0, 0), ov(1, 0, 'h600, 0, WW, 0, 0, 0, 0));
    add(iv(0, 1, 'h500, 1, 0, 'h600, 0, WW, 1, 'hD0D0D0D0),
        ov(0, 0, 'h600, 0, WW, 0, 1, 0, 'hD0D0D0D0));
    add(iv(0, 1, 'h500, 1, 0, 'h600, 0, WW, 0, 0), ov(0, 0, 'h600, 0, WW, 0, 0, 0, 'hD0D0D0D0));
    add(iv(0, 1, 'h500, 1, 0, 'h600, 0, WW, 0, 0), ov(1, 0, 'h500, 0, WW, 0, 0, 0, 'hD0D0D0D0));
    add(iv(0, 1, 'h500, 1, 0, 'h600, 0, WW, 1, 'h1A1A1A1A),
        ov(0, 0, 'h500, 0, WW, 1, 0, 'h1A1A1A1A, 'hD0D0D0D0));
    add(iv(0, 1, 'h500, 1, 0, 'h600, 0, WW, 0, 0),
        ov(0, 0, 'h500, 0, WW, 0, 0, 'h1A1A1A1A, 'hD0D0D0D0));
    add(iv(0, 1, 'h500, 1, 0, 'h600, 0, WW, 0, 0),
        ov(1, 0, 'h600, 0, WW, 0, 0, 'h1A1A1A1A, 'hD0D0D0D0));
    add(iv(0, 1, 'h500, 1, 0, 'h600, 0, WW, 1, 'hD1D1D1D1),
        ov(0, 0, 'h600, 0, WW, 0, 1, 'h1A1A1A1A, 'hD1D1D1D1));
    add(iv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ov(0, 0, 'h600, 0, WW, 0, 0, 'h1A1A1A1A, 'hD1D1D1D1));
    // dren and dwen together behave as a store; dload untouched
    add(iv(0, 0, 0, 1, 1, 'h700, 'h55, WW, 0, 0),
        ov(1, 1, 'h700, 'h55, WW, 0, 0, 'h1A1A1A1A, 'hD1D1D1D1));
    add(iv(0, 0, 0, 1, 1, 'h700, 'h55, WW, 1, 'hEEEEEEEE),
        ov(0, 1, 'h700, 'h55, WW, 0, 1, 'h1A1A1A1A, 'hD1D1D1D1));
    add(iv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
        ov(0, 1, 'h700, 'h55, WW, 0, 0, 'h1A1A1A1A, 'hD1D1D1D1));

    foreach (vecs[k]) begin
      @(negedge clk);
      nrst      = vecs[k].i.rst;
      iren      = vecs[k].i.iren;
      iaddr     = vecs[k].i.iaddr;
      dren      = vecs[k].i.dren;
      dwen      = vecs[k].i.dwen;
      daddr     = vecs[k].i.daddr;
      dstore    = vecs[k].i.dstore;
      dwidth    = vecs[k].i.dwidth;
      ram_ack   = vecs[k].i.ack;
      ram_rdata = vecs[k].i.rdata;
      @(posedge clk);
      #1;
      act = sample();
      check($sformatf("vec%0d", k), act == vecs[k].o, $sformatf("%h", act),
            $sformatf("%h", vecs[k].o));
    end

    // Continuous conflict with variable RAM latency; last table grant was D,
    // so grants must run I, D, I, D, I, D.
    iren = 1'b1; iaddr = 32'h800;
    dren = 1'b1; dwen = 1'b0; daddr = 32'h900; dstore = '0; dwidth = WW;
    ram_ack = 1'b0;
    for (int g = 0; g < 6; g++) begin
      int n;
      logic        want_i;
      logic [31:0] rd;
      want_i = (g % 2) == 0;
      rd     = 32'hC0DE_0000 + 32'(g);
      n = 0;
      while (!ram_req && n < 5) begin
        @(posedge clk);
        #1;
        n++;
      end
      check($sformatf("rr%0d_grant", g),
            ram_req && ram_addr == (want_i ? 32'h800 : 32'h900) && !ram_wen,
            $sformatf("req=%0b addr=%h wen=%0b", ram_req, ram_addr, ram_wen),
            $sformatf("req=1 addr=%h wen=0", want_i ? 32'h800 : 32'h900));
      repeat (g % 3) begin
        @(posedge clk);
        #1;
      end
      ram_ack = 1'b1;
      ram_rdata = rd;
      @(posedge clk);
      #1;
      ram_ack = 1'b0;
      if (want_i) begin
        check($sformatf("rr%0d_ihit", g), ihit && !dhit && idata == rd && !ram_req,
              $sformatf("ihit=%0b dhit=%0b idata=%h req=%0b", ihit, dhit, idata, ram_req),
              $sformatf("ihit=1 dhit=0 idata=%h req=0", rd));
      end else begin
        check($sformatf("rr%0d_dhit", g), dhit && !ihit && dload == rd && !ram_req,
              $sformatf("ihit=%0b dhit=%0b dload=%h req=%0b", ihit, dhit, dload, ram_req),
              $sformatf("ihit=0 dhit=1 dload=%h req=0", rd));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
